// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared types and default widths for the PE array lane MAC
package pe_array_pkg;

  localparam int NUM_PE_DEF    = 4;
  localparam int NUM_LANES_DEF = 2;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 24;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_MAC  = 2'd1,
    OP_ADD  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    CNTL_MOM     = 2'b00,
    CNTL_SOM     = 2'b01,
    CNTL_EOM     = 2'b10,
    CNTL_SOM_EOM = 2'b11
  } cntl_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WRITE  = 2'd2
  } lane_state_e;

  // Reserved opcodes behave like NOP, so only MAC and ADD arm a lane.
  function automatic logic op_active(input logic [1:0] op);
    return (op == OP_MAC) || (op == OP_ADD);
  endfunction

  function automatic logic cntl_is_end(input logic [1:0] cntl);
    return (cntl == CNTL_EOM) || (cntl == CNTL_SOM_EOM);
  endfunction

endpackage

// File: rtl/pe_array_lane.sv
// rtl/pe_array_lane.sv - one execution lane: stream FSM, accumulator and DMA write port
module pe_array_lane
  import pe_array_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              strm0_valid,
  input  logic [DATA_W-1:0] strm0_data,
  input  logic [1:0]        strm0_cntl,
  input  logic              strm1_valid,
  input  logic [DATA_W-1:0] strm1_data,
  input  logic [1:0]        strm1_cntl,
  output logic              strm_ready,
  output logic              idle,
  output logic              write_valid,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_ready,
  output logic              stream_err
);

  lane_state_e       state;
  op_e               op;
  logic [ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0] acc;

  logic              fire;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] term;

  // Both operands must be present together; a lone valid is left waiting.
  assign fire = (state == ST_STREAM) && strm0_valid && strm1_valid;
  assign prod = strm0_data * strm1_data;
  assign sum  = strm0_data + strm1_data;
  assign term = (op == OP_MAC) ? prod : sum;

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      state       <= ST_IDLE;
      op          <= OP_NOP;
      dest_addr   <= '0;
      acc         <= '0;
      stream_err  <= 1'b0;
      strm_ready  <= 1'b0;
      write_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op        <= op_e'(cmd_op);
            dest_addr <= cmd_addr;
            acc       <= '0;
            if (op_active(cmd_op)) begin
              state      <= ST_STREAM;
              strm_ready <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (fire) begin
            acc <= acc + term;
            if (strm0_cntl != strm1_cntl) begin
              stream_err <= 1'b1;
            end
            if (cntl_is_end(strm0_cntl) || cntl_is_end(strm1_cntl)) begin
              state       <= ST_WRITE;
              strm_ready  <= 1'b0;
              write_valid <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (write_ready) begin
            state       <= ST_IDLE;
            write_valid <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          strm_ready  <= 1'b0;
          write_valid <= 1'b0;
        end
      endcase
    end
  end

  assign idle          = (state == ST_IDLE);
  assign write_address = dest_addr;
  assign write_data    = acc;

endmodule

// File: rtl/pe_array_lane_mac.sv
// rtl/pe_array_lane_mac.sv - PE array top: lane instances plus per-PE OOB command accept and broadcast
module pe_array_lane_mac
  import pe_array_pkg::*;
#(
  parameter int NUM_PE    = NUM_PE_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                                clk,
  input  logic                                reset_poweron,
  input  logic [NUM_PE*NUM_LANES-1:0]         std__pe__strm0_valid,
  input  logic [NUM_PE*NUM_LANES*DATA_W-1:0]  std__pe__strm0_data,
  input  logic [NUM_PE*NUM_LANES*2-1:0]       std__pe__strm0_cntl,
  input  logic [NUM_PE*NUM_LANES-1:0]         std__pe__strm1_valid,
  input  logic [NUM_PE*NUM_LANES*DATA_W-1:0]  std__pe__strm1_data,
  input  logic [NUM_PE*NUM_LANES*2-1:0]       std__pe__strm1_cntl,
  output logic [NUM_PE*NUM_LANES-1:0]         pe__std__strm_ready,
  input  logic [NUM_PE-1:0]                   sys__pe__oob_valid,
  input  logic [NUM_PE*2-1:0]                 sys__pe__oob_op,
  input  logic [NUM_PE*ADDR_W-1:0]            sys__pe__oob_dest_addr,
  output logic [NUM_PE-1:0]                   pe__sys__oob_ready,
  output logic [NUM_PE*NUM_LANES-1:0]         dma__memc__write_valid,
  output logic [NUM_PE*NUM_LANES*ADDR_W-1:0]  dma__memc__write_address,
  output logic [NUM_PE*NUM_LANES*DATA_W-1:0]  dma__memc__write_data,
  input  logic [NUM_PE*NUM_LANES-1:0]         memc__dma__write_ready,
  output logic [NUM_PE*NUM_LANES-1:0]         pe__sys__stream_err
);

  localparam int NUM_ALL = NUM_PE * NUM_LANES;

  logic [NUM_ALL-1:0] lane_idle;
  logic [NUM_PE-1:0]  oob_accept;
  logic               rst_done;

  // Holds oob_ready low while reset is applied even though every lane reads IDLE.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    assign pe__sys__oob_ready[p] = rst_done && (&lane_idle[p*NUM_LANES +: NUM_LANES]);
    assign oob_accept[p]         = sys__pe__oob_valid[p] && pe__sys__oob_ready[p];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      localparam int IDX = p * NUM_LANES + l;

      pe_array_lane #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .cmd_valid     (oob_accept[p]),
        .cmd_op        (sys__pe__oob_op[p*2 +: 2]),
        .cmd_addr      (sys__pe__oob_dest_addr[p*ADDR_W +: ADDR_W]),
        .strm0_valid   (std__pe__strm0_valid[IDX]),
        .strm0_data    (std__pe__strm0_data[IDX*DATA_W +: DATA_W]),
        .strm0_cntl    (std__pe__strm0_cntl[IDX*2 +: 2]),
        .strm1_valid   (std__pe__strm1_valid[IDX]),
        .strm1_data    (std__pe__strm1_data[IDX*DATA_W +: DATA_W]),
        .strm1_cntl    (std__pe__strm1_cntl[IDX*2 +: 2]),
        .strm_ready    (pe__std__strm_ready[IDX]),
        .idle          (lane_idle[IDX]),
        .write_valid   (dma__memc__write_valid[IDX]),
        .write_address (dma__memc__write_address[IDX*ADDR_W +: ADDR_W]),
        .write_data    (dma__memc__write_data[IDX*DATA_W +: DATA_W]),
        .write_ready   (memc__dma__write_ready[IDX]),
        .stream_err    (pe__sys__stream_err[IDX])
      );
    end
  end

endmodule

// File: tb/tb_pe_array_lane_mac.sv
// tb/tb_pe_array_lane_mac.sv - directed self-checking bench for pe_array_lane_mac
module tb_pe_array_lane_mac;

  localparam int NP = 4;
  localparam int NL = 2;
  localparam int NA = NP * NL;
  localparam int DW = 32;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NA-1:0]    s0v, s1v;
  logic [NA*DW-1:0] s0d, s1d;
  logic [NA*2-1:0]  s0c, s1c;
  logic [NA-1:0]    strm_ready;
  logic [NP-1:0]    oob_valid;
  logic [NP*2-1:0]  oob_op;
  logic [NP*AW-1:0] oob_addr;
  logic [NP-1:0]    oob_ready;
  logic [NA-1:0]    wv;
  logic [NA*AW-1:0] wa;
  logic [NA*DW-1:0] wd;
  logic [NA-1:0]    wr;
  logic [NA-1:0]    err;

  int checks = 0;
  int failures = 0;
  int wcnt [NA];

  always #5 clk = ~clk;

  pe_array_lane_mac dut (
    .clk                      (clk),
    .reset_poweron            (rstn),
    .std__pe__strm0_valid     (s0v),
    .std__pe__strm0_data      (s0d),
    .std__pe__strm0_cntl      (s0c),
    .std__pe__strm1_valid     (s1v),
    .std__pe__strm1_data      (s1d),
    .std__pe__strm1_cntl      (s1c),
    .pe__std__strm_ready      (strm_ready),
    .sys__pe__oob_valid       (oob_valid),
    .sys__pe__oob_op          (oob_op),
    .sys__pe__oob_dest_addr   (oob_addr),
    .pe__sys__oob_ready       (oob_ready),
    .dma__memc__write_valid   (wv),
    .dma__memc__write_address (wa),
    .dma__memc__write_data    (wd),
    .memc__dma__write_ready   (wr),
    .pe__sys__stream_err      (err)
  );

  // Completed write handshakes per lane, sampled mid-cycle.
  always @(negedge clk) begin
    for (int l = 0; l < NA; l++) begin
      if (rstn && wv[l] && wr[l]) wcnt[l] = wcnt[l] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] wdl(input int l);
    return wd[l*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] wal(input int l);
    return wa[l*AW +: AW];
  endfunction

  task automatic pair(input int l, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] c0, input logic [1:0] c1);
    s0v[l] = 1'b1;
    s1v[l] = 1'b1;
    s0d[l*DW +: DW] = a;
    s1d[l*DW +: DW] = b;
    s0c[l*2 +: 2] = c0;
    s1c[l*2 +: 2] = c1;
  endtask

  task automatic unpair(input int l);
    s0v[l] = 1'b0;
    s1v[l] = 1'b0;
  endtask

  task automatic oob(input int p, input logic [1:0] op, input logic [AW-1:0] addr);
    int n;
    n = 0;
    while (!oob_ready[p] && n < 50) begin
      tick();
      n++;
    end
    chk("oob_ready_wait", {63'd0, oob_ready[p]}, 64'd1);
    oob_valid[p] = 1'b1;
    oob_op[p*2 +: 2] = op;
    oob_addr[p*AW +: AW] = addr;
    tick();
    oob_valid[p] = 1'b0;
  endtask

  initial begin
    int total;
    for (int l = 0; l < NA; l++) wcnt[l] = 0;
    rstn = 1'b0;
    s0v = '0; s1v = '0; s0d = '0; s1d = '0; s0c = '0; s1c = '0;
    oob_valid = '0; oob_op = '0; oob_addr = '0;
    wr = '1;

    // reset and idle
    repeat (3) tick();
    chk("rst_oob_ready_low", 64'(oob_ready), 64'h0);
    rstn = 1'b1;
    tick();
    chk("idle_write_valid", 64'(wv), 64'h0);
    chk("idle_strm_ready", 64'(strm_ready), 64'h0);
    chk("idle_oob_ready", 64'(oob_ready), 64'hF);
    chk("idle_stream_err", 64'(err), 64'h0);

    // PE0 MAC: lane0 (2,3),(4,5),(6,7) -> 68; lane1 (1,1) -> 1
    oob(0, 2'd1, 24'h000100);
    chk("mac_oob_ready_drop", {63'd0, oob_ready[0]}, 64'd0);
    chk("mac_strm_ready", 64'(strm_ready), 64'h3);
    s0v[0] = 1'b1; s0d[0 +: DW] = 32'd100; s0c[1:0] = 2'b10;
    tick();
    s0v[0] = 1'b0;
    chk("lone_valid_still_stream", {63'd0, strm_ready[0]}, 64'd1);
    pair(0, 32'd2, 32'd3, 2'b01, 2'b01);
    pair(1, 32'd1, 32'd1, 2'b11, 2'b11);
    tick();
    unpair(1);
    chk("pe0_l1_wv", {63'd0, wv[1]}, 64'd1);
    chk("pe0_l1_wd", 64'(wdl(1)), 64'd1);
    chk("pe0_l1_wa", 64'(wal(1)), 64'h100);
    pair(0, 32'd4, 32'd5, 2'b00, 2'b00);
    tick();
    pair(0, 32'd6, 32'd7, 2'b10, 2'b10);
    tick();
    unpair(0);
    chk("pe0_l0_wv", {63'd0, wv[0]}, 64'd1);
    chk("pe0_l0_wa", 64'(wal(0)), 64'h100);
    chk("pe0_l0_wd", 64'(wdl(0)), 64'd68);
    tick();
    chk("pe0_l0_wv_done", {63'd0, wv[0]}, 64'd0);
    chk("pe0_l0_wcnt", 64'(wcnt[0]), 64'd1);
    chk("pe0_l1_wcnt", 64'(wcnt[1]), 64'd1);
    chk("pe0_oob_ready_back", {63'd0, oob_ready[0]}, 64'd1);

    // PE1 ADD: wrap 0xFFFFFFFF+2 -> 1; lane3 5+6 -> 11
    oob(1, 2'd2, 24'h000200);
    pair(2, 32'hFFFF_FFFF, 32'd2, 2'b11, 2'b11);
    pair(3, 32'd5, 32'd6, 2'b11, 2'b11);
    tick();
    unpair(2); unpair(3);
    chk("add_wv_only_pe1", 64'(wv), 64'h0C);
    chk("add_wrap_wd", 64'(wdl(2)), 64'h1);
    chk("add_wa", 64'(wal(2)), 64'h200);
    chk("add_l3_wd", 64'(wdl(3)), 64'd11);
    tick();
    chk("add_wcnt", 64'(wcnt[2]), 64'd1);

    // PE3 MAC with lane6 write_ready held low for 5 cycles
    wr[6] = 1'b0;
    oob(3, 2'd1, 24'h000300);
    pair(6, 32'd3, 32'd4, 2'b01, 2'b01);
    pair(7, 32'd7, 32'd8, 2'b11, 2'b11);
    tick();
    unpair(7);
    chk("stall_l7_wd", 64'(wdl(7)), 64'd56);
    pair(6, 32'd5, 32'd6, 2'b10, 2'b10);
    tick();
    unpair(6);
    for (int i = 0; i < 5; i++) begin
      chk("stall_wv", {63'd0, wv[6]}, 64'd1);
      chk("stall_wa", 64'(wal(6)), 64'h300);
      chk("stall_wd", 64'(wdl(6)), 64'd42);
      chk("stall_oob_ready", {63'd0, oob_ready[3]}, 64'd0);
      tick();
    end
    wr[6] = 1'b1;
    tick();
    chk("stall_wv_done", {63'd0, wv[6]}, 64'd0);
    chk("stall_oob_ready_back", {63'd0, oob_ready[3]}, 64'd1);
    chk("stall_wcnt6", 64'(wcnt[6]), 64'd1);
    chk("stall_wcnt7", 64'(wcnt[7]), 64'd1);

    // PE2 framing mismatch on lane4
    oob(2, 2'd1, 24'h000400);
    pair(4, 32'd2, 32'd3, 2'b10, 2'b00);
    pair(5, 32'd1, 32'd2, 2'b11, 2'b11);
    tick();
    unpair(4); unpair(5);
    chk("err_set", 64'(err), 64'h10);
    chk("err_wv", {63'd0, wv[4]}, 64'd1);
    chk("err_wd", 64'(wdl(4)), 64'd6);
    chk("err_l5_wd", 64'(wdl(5)), 64'd2);
    tick();
    tick();
    chk("err_sticky", 64'(err), 64'h10);

    // PE2 reset mid-stream
    oob(2, 2'd1, 24'h000480);
    pair(4, 32'd9, 32'd9, 2'b01, 2'b01);
    tick();
    unpair(4);
    chk("mid_strm_ready", 64'(strm_ready[5:4]), 64'h3);
    chk("mid_err_still", 64'(err), 64'h10);
    rstn = 1'b0;
    tick();
    chk("mid_rst_wv", 64'(wv), 64'h0);
    chk("mid_rst_strm_ready", 64'(strm_ready), 64'h0);
    chk("mid_rst_oob_ready", 64'(oob_ready), 64'h0);
    rstn = 1'b1;
    tick();
    chk("post_rst_oob_ready", 64'(oob_ready), 64'hF);
    chk("post_rst_err", 64'(err), 64'h0);
    chk("post_rst_no_write", 64'(wcnt[4]), 64'd1);
    oob(2, 2'd1, 24'h000500);
    pair(4, 32'd1, 32'd1, 2'b11, 2'b11);
    pair(5, 32'd2, 32'd2, 2'b11, 2'b11);
    tick();
    unpair(4); unpair(5);
    chk("post_rst_wd", 64'(wdl(4)), 64'd1);
    chk("post_rst_wa", 64'(wal(4)), 64'h500);
    chk("post_rst_l5_wd", 64'(wdl(5)), 64'd4);
    tick();

    total = 0;
    for (int l = 0; l < NA; l++) total += wcnt[l];
    chk("total_writes", 64'(total), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
